capture_buffer_pretrig: RTL

Parametrised single-clock successor to the ADC capture store. Continuously records multi-lane sample words into a circular buffer once armed. On a trigger it keeps a programmable number of pre-trigger words and fills the rest with post-trigger words. It then serialises the captured record, one lane-sample per cycle, to the byte-wide transmit path under a ReadEnable handshake.

---
 rtl/capture_buffer_pretrig_if.sv | 30 +++
 rtl/capture_buffer_pretrig.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer_pretrig_if.sv
// Bus bundle for the pre-trigger capture buffer: sample input, trigger
// controls, readout handshake and status.
interface capture_buffer_pretrig_if #(
    parameter int LANES        = 4,
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10
);
    logic [LANES*SAMPLE_WIDTH-1:0] DataIn;
    logic                          DataInValid;
    logic                          Arm;
    logic                          WriteStrobe;
    logic [ADDR_WIDTH-1:0]         PreTrigCount;
    logic                          ReadEnable;
    logic [SAMPLE_WIDTH-1:0]       DataOut;
    logic                          DataValid;
    logic                          DataReadyToSend;
    logic [1:0]                    State;

    // Producer/consumer side driving samples and pulling the record out.
    modport master (
        output DataIn, DataInValid, Arm, WriteStrobe, PreTrigCount, ReadEnable,
        input  DataOut, DataValid, DataReadyToSend, State
    );

    // Capture buffer side.
    modport slave (
        input  DataIn, DataInValid, Arm, WriteStrobe, PreTrigCount, ReadEnable,
        output DataOut, DataValid, DataReadyToSend, State
    );
endinterface

// File: rtl/capture_buffer_pretrig.sv
// Circular multi-lane capture store with a programmable pre-trigger window.
// Once armed it records every valid word; a qualified trigger freezes the
// window start, the remaining words are filled post-trigger, and the record
// is then streamed out one lane-sample per ReadEnable, lane 0 / oldest first.
// LANES must be at least 2 so the next word is prefetched before its first
// lane is needed.
module capture_buffer_pretrig #(
    parameter int LANES        = 4,
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                      Clock,
    input  logic                      Reset,
    capture_buffer_pretrig_if.slave   bus
);
    localparam int WORD_WIDTH = LANES * SAMPLE_WIDTH;
    localparam int LANE_BITS  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW1        = ADDR_WIDTH + 1;

    localparam logic [AW1-1:0]        DEPTH_FULL = AW1'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [LANE_BITS-1:0]  LAST_LANE  = LANE_BITS'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  stateNext_s;

    logic [WORD_WIDTH-1:0]   mem_r [DEPTH];
    logic [WORD_WIDTH-1:0]   ramData_r;
    logic [WORD_WIDTH-1:0]   curWord_r;
    logic [ADDR_WIDTH-1:0]   wrPtr_r;
    logic [ADDR_WIDTH-1:0]   rdPtr_r;
    logic [ADDR_WIDTH-1:0]   pre_r;
    logic [ADDR_WIDTH-1:0]   wordCnt_r;
    logic [AW1-1:0]          fill_r;
    logic [AW1-1:0]          postLeft_r;
    logic [LANE_BITS-1:0]    laneIdx_r;
    logic                    loadStep_r;
    logic                    ready_r;
    logic [SAMPLE_WIDTH-1:0] dataOut_r;
    logic                    dataValid_r;

    logic                    trigger_s;
    logic                    doWrite_s;
    logic                    issue_s;
    logic                    lastIssue_s;
    logic [AW1-1:0]          postInit_s;

    // Requests wider than the record are clamped so at least one post word remains.
    function automatic logic [ADDR_WIDTH-1:0] clampPre(input logic [ADDR_WIDTH-1:0] req);
        logic [31:0] reqWide;
        reqWide = 32'(req);
        if (reqWide > 32'(DEPTH - 1)) begin
            return LAST_WORD;
        end else begin
            return req;
        end
    endfunction

    // Pick one lane-sample out of a stored word.
    function automatic logic [SAMPLE_WIDTH-1:0] laneSel(input logic [WORD_WIDTH-1:0] word,
                                                        input logic [LANE_BITS-1:0]  idx);
        logic [SAMPLE_WIDTH-1:0] sel;
        sel = {SAMPLE_WIDTH{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (idx == LANE_BITS'(i)) begin
                sel = word[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
        return sel;
    endfunction

    // fill is compared before this cycle's write; Arm in the same cycle wins.
    assign trigger_s   = (state_r == ST_ARMED) && bus.WriteStrobe && !bus.Arm &&
                         (fill_r >= {1'b0, pre_r});
    assign doWrite_s   = !Reset && bus.DataInValid &&
                         (((state_r == ST_ARMED) && !bus.Arm) || (state_r == ST_CAPTURE));
    assign issue_s     = (state_r == ST_READOUT) && ready_r && bus.ReadEnable;
    assign lastIssue_s = issue_s && (laneIdx_r == LAST_LANE) && (wordCnt_r == LAST_WORD);
    assign postInit_s  = DEPTH_FULL - {1'b0, pre_r};

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state decode.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Arm) begin
                    stateNext_s = ST_ARMED;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (trigger_s && bus.DataInValid && (postInit_s == AW1'(1))) begin
                    stateNext_s = ST_READOUT;
                end else if (trigger_s) begin
                    stateNext_s = ST_CAPTURE;
                end else begin
                    stateNext_s = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (bus.DataInValid && (postLeft_r == AW1'(1))) begin
                    stateNext_s = ST_READOUT;
                end else begin
                    stateNext_s = ST_CAPTURE;
                end
            end
            ST_READOUT: begin
                if (lastIssue_s) begin
                    stateNext_s = ST_IDLE;
                end else begin
                    stateNext_s = ST_READOUT;
                end
            end
            default: stateNext_s = ST_IDLE;
        endcase
    end

    // Sample RAM: write port from the capture path, registered read for readout.
    always_ff @(posedge Clock) begin
        if (doWrite_s) begin
            mem_r[wrPtr_r] <= bus.DataIn;
        end
        ramData_r <= mem_r[rdPtr_r];
    end

    // Pointers, counters and the serialised output.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr_r     <= {ADDR_WIDTH{1'b0}};
            rdPtr_r     <= {ADDR_WIDTH{1'b0}};
            pre_r       <= {ADDR_WIDTH{1'b0}};
            wordCnt_r   <= {ADDR_WIDTH{1'b0}};
            fill_r      <= {AW1{1'b0}};
            postLeft_r  <= {AW1{1'b0}};
            laneIdx_r   <= {LANE_BITS{1'b0}};
            loadStep_r  <= 1'b0;
            ready_r     <= 1'b0;
            curWord_r   <= {WORD_WIDTH{1'b0}};
            dataOut_r   <= {SAMPLE_WIDTH{1'b0}};
            dataValid_r <= 1'b0;
        end else begin
            dataValid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ARMED: begin
                    if (bus.Arm) begin
                        wrPtr_r <= {ADDR_WIDTH{1'b0}};
                        fill_r  <= {AW1{1'b0}};
                        pre_r   <= clampPre(bus.PreTrigCount);
                    end else if (state_r == ST_ARMED) begin
                        if (bus.DataInValid) begin
                            wrPtr_r <= wrPtr_r + ADDR_WIDTH'(1);
                            if (fill_r != DEPTH_FULL) begin
                                fill_r <= fill_r + AW1'(1);
                            end
                        end
                        if (trigger_s) begin
                            // Window start is pre words behind the trigger word.
                            rdPtr_r    <= wrPtr_r - pre_r;
                            postLeft_r <= bus.DataInValid ? (postInit_s - AW1'(1)) : postInit_s;
                            laneIdx_r  <= {LANE_BITS{1'b0}};
                            wordCnt_r  <= {ADDR_WIDTH{1'b0}};
                            loadStep_r <= 1'b0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (bus.DataInValid) begin
                        wrPtr_r    <= wrPtr_r + ADDR_WIDTH'(1);
                        postLeft_r <= postLeft_r - AW1'(1);
                    end
                end
                ST_READOUT: begin
                    if (!ready_r) begin
                        // First cycle waits for the RAM read, second latches the oldest word.
                        if (!loadStep_r) begin
                            loadStep_r <= 1'b1;
                        end else begin
                            curWord_r <= ramData_r;
                            rdPtr_r   <= rdPtr_r + ADDR_WIDTH'(1);
                            ready_r   <= 1'b1;
                        end
                    end else if (issue_s) begin
                        dataOut_r   <= laneSel(curWord_r, laneIdx_r);
                        dataValid_r <= 1'b1;
                        if (laneIdx_r == LAST_LANE) begin
                            laneIdx_r <= {LANE_BITS{1'b0}};
                            curWord_r <= ramData_r;
                            rdPtr_r   <= rdPtr_r + ADDR_WIDTH'(1);
                            wordCnt_r <= wordCnt_r + ADDR_WIDTH'(1);
                            if (wordCnt_r == LAST_WORD) begin
                                ready_r <= 1'b0;
                            end
                        end else begin
                            laneIdx_r <= laneIdx_r + LANE_BITS'(1);
                        end
                    end
                end
                default: begin
                    dataValid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DataOut         = dataOut_r;
    assign bus.DataValid       = dataValid_r;
    assign bus.DataReadyToSend = ready_r;
    assign bus.State           = state_r;
endmodule
